dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller for the 8-bit CPU. It sits between the CPU's memory-access port (ALU result as address, register-file output as write data) and the 32-bit-word data memory. It owns the tag/valid/dirty arrays and the 8×32-bit block store, and sequences miss handling with a four-state FSM. While any miss is being serviced it stalls the CPU through `busywait`.

---
 rtl/dcache_controller_if.sv | 35 +++
 rtl/dcache_controller.sv | 128 ++++++++++++
 tb/tb_dcache_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU-side and memory-side bus bundle for dcache_controller
//
// Signals:
//   CPU side    : read, write, address[7:0], writedata[7:0] -> cache
//                 readdata[7:0], busywait                   <- cache
//   Memory side : mem_read, mem_write, mem_address[5:0],
//                 mem_writedata[31:0]                       <- cache
//                 mem_readdata[31:0], mem_busywait          -> cache
// Modports:
//   slave  : the cache controller
//   master : the environment (CPU plus data memory)
interface dcache_controller_if;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
//
// Geometry: 8 blocks x 4 bytes; tag=address[7:5], index=address[4:2], offset=address[1:0].
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   bus (slave modport) : CPU request/response and 32-bit block memory port
//   hit_count[15:0]     : requests that hit on first evaluation   (DCACHE_PERF_EN only)
//   miss_count[15:0]    : requests that missed on first evaluation (DCACHE_PERF_EN only)
// Optional feature macro: DCACHE_PERF_EN (adds the hit/miss counters).
module dcache_controller (
    input  logic                 clock,
    input  logic                 reset,
    dcache_controller_if.slave   bus
`ifdef DCACHE_PERF_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t      state_q, state_d;
    logic [31:0] block_q [8];
    logic [2:0]  tag_q   [8];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;

    logic [2:0]  tag;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic        req;
    logic        hit;

    assign tag    = bus.address[7:5];
    assign index  = bus.address[4:2];
    assign offset = bus.address[1:0];
    assign req    = bus.read | bus.write;
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    assign bus.readdata = block_q[index][{offset, 3'b000} +: 8];

    always_comb begin
        state_d           = state_q;
        bus.busywait      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = 6'h00;
        bus.mem_writedata = 32'h0;
        case (state_q)
            IDLE: begin
                bus.busywait = req && !hit;
                if (req && !hit)
                    state_d = dirty_q[index] ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                bus.busywait      = 1'b1;
                bus.mem_write     = 1'b1;
                bus.mem_address   = {tag_q[index], index};
                bus.mem_writedata = block_q[index];
                if (!bus.mem_busywait)
                    state_d = FETCH;
            end
            FETCH: begin
                bus.busywait    = 1'b1;
                bus.mem_read    = 1'b1;
                bus.mem_address = bus.address[7:2];
                if (!bus.mem_busywait)
                    state_d = UPDATE;
            end
            UPDATE: begin
                bus.busywait = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Block and tag storage carry no reset: valid_q gates every use of them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 8'h00;
            dirty_q <= 8'h00;
        end else begin
            state_q <= state_d;
            // write has priority when read and write are both asserted
            if (state_q == IDLE && bus.write && hit) begin
                block_q[index][{offset, 3'b000} +: 8] <= bus.writedata;
                dirty_q[index]                        <= 1'b1;
            end
            if (state_q == FETCH && !bus.mem_busywait) begin
                block_q[index] <= bus.mem_readdata;
                tag_q[index]   <= tag;
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

`ifdef DCACHE_PERF_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;
    logic        after_update_q;

    // The first IDLE cycle after UPDATE re-evaluates a request that was
    // already counted as a miss, so it is excluded from counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q    <= 16'h0000;
            miss_count_q   <= 16'h0000;
            after_update_q <= 1'b0;
        end else begin
            after_update_q <= (state_q == UPDATE);
            if (state_q == IDLE && req && !after_update_q) begin
                if (hit)
                    hit_count_q  <= hit_count_q + 16'h0001;
                else
                    miss_count_q <= miss_count_q + 16'h0001;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller
module tb_dcache_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dcache_controller_if bus();

`ifdef DCACHE_PERF_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DCACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Memory model: busy from the first cycle of an access, ready on cycle LAT.
    localparam int LAT = 5;
    logic [1:0] op;
    logic [1:0] op_q  = 2'b00;
    int         cnt_q = 0;

    assign op               = {bus.mem_read, bus.mem_write};
    assign bus.mem_busywait = (op != 2'b00) && !(op == op_q && cnt_q == LAT - 2);
    assign bus.mem_readdata = (bus.mem_address == 6'h08) ? 32'h44332211 :
                              (bus.mem_address == 6'h00) ? 32'hDDCCBBAA : 32'h0;

    always @(posedge clock) begin
        op_q  <= op;
        cnt_q <= (op != 2'b00 && op == op_q) ? cnt_q + 1 : 0;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follows a stall from its current cycle until busywait drops (bounded).
    task automatic run_miss(output int busy, output logic saw_wb, output logic saw_upd,
                            output logic [5:0] wb_addr, output logic [31:0] wb_data,
                            output logic [5:0] f_addr);
        busy    = 0;
        saw_wb  = 1'b0;
        saw_upd = 1'b0;
        wb_addr = 6'h3F;
        wb_data = 32'h0;
        f_addr  = 6'h3F;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!bus.busywait) break;
            busy++;
            if (bus.mem_write) begin
                saw_wb  = 1'b1;
                wb_addr = bus.mem_address;
                wb_data = bus.mem_writedata;
            end
            if (bus.mem_read) f_addr = bus.mem_address;
            if (dut.state_q == 2'd3) saw_upd = 1'b1;
        end
    endtask

    int          busy;
    int          fcnt;
    logic        saw_wb;
    logic        saw_upd;
    logic [5:0]  wb_addr;
    logic [5:0]  f_addr;
    logic [31:0] wb_data;

    initial begin
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 8'h00;
        bus.writedata = 8'h00;

        // reset state
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busywait", {31'b0, bus.busywait}, 32'd0);
        chk("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        chk("rst_mem_address", {26'b0, bus.mem_address}, 32'd0);
        chk("rst_mem_writedata", bus.mem_writedata, 32'd0);
        chk("rst_state", {30'b0, dut.state_q}, 32'd0);

        // clean read miss at 0x00
        @(posedge clock);
        #1 bus.read = 1'b1; bus.address = 8'h00;
        run_miss(busy, saw_wb, saw_upd, wb_addr, wb_data, f_addr);
        chk("clean_busy_cycles", busy, 32'd7);
        chk("clean_no_writeback", {31'b0, saw_wb}, 32'd0);
        chk("clean_fetch_addr", {26'b0, f_addr}, 32'h00);
        chk("clean_saw_update", {31'b0, saw_upd}, 32'd1);
        chk("clean_readdata", {24'b0, bus.readdata}, 32'hAA);

        // read hit at 0x01
        @(posedge clock);
        #1 bus.address = 8'h01;
        @(negedge clock);
        chk("hit_busywait", {31'b0, bus.busywait}, 32'd0);
        chk("hit_readdata", {24'b0, bus.readdata}, 32'hBB);
        chk("hit_no_mem_read", {31'b0, bus.mem_read}, 32'd0);

        // write hit 0x5A at 0x02
        @(posedge clock);
        #1 bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h02; bus.writedata = 8'h5A;
        @(negedge clock);
        chk("whit_busywait", {31'b0, bus.busywait}, 32'd0);
        @(posedge clock);
        #1 bus.write = 1'b0; bus.read = 1'b1; bus.address = 8'h02;
        @(negedge clock);
        chk("whit_dirty0", {31'b0, dut.dirty_q[0]}, 32'd1);
        chk("whit_readback", {24'b0, bus.readdata}, 32'h5A);
        chk("whit_readback_busy", {31'b0, bus.busywait}, 32'd0);

        // dirty eviction: read 0x22 maps to index 0 with tag 1
        @(posedge clock);
        #1 bus.address = 8'h22;
        run_miss(busy, saw_wb, saw_upd, wb_addr, wb_data, f_addr);
        chk("evict_busy_cycles", busy, 32'd12);
        chk("evict_saw_wb", {31'b0, saw_wb}, 32'd1);
        chk("evict_wb_addr", {26'b0, wb_addr}, 32'h00);
        chk("evict_wb_data", wb_data, 32'hDD5ABBAA);
        chk("evict_fetch_addr", {26'b0, f_addr}, 32'h08);
        chk("evict_readdata", {24'b0, bus.readdata}, 32'h33);
        chk("evict_dirty_clear", {31'b0, dut.dirty_q[0]}, 32'd0);

        @(posedge clock);
        #1 bus.read = 1'b0;
        @(negedge clock);
`ifdef DCACHE_PERF_EN
        chk("perf_hits", {16'b0, hit_count}, 32'd3);
        chk("perf_misses", {16'b0, miss_count}, 32'd2);
`endif

        // reset during the 3rd FETCH cycle of a clean miss on 0x00
        @(posedge clock);
        #1 bus.read = 1'b1; bus.address = 8'h00;
        fcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.mem_read) fcnt++;
            if (fcnt == 3) break;
        end
        chk("rstf_fetch_cycles", fcnt, 32'd3);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rstf_mem_read", {31'b0, bus.mem_read}, 32'd0);
        chk("rstf_state", {30'b0, dut.state_q}, 32'd0);
        chk("rstf_valid", {24'b0, dut.valid_q}, 32'd0);
        chk("rstf_misses_again", {31'b0, bus.busywait}, 32'd1);
`ifdef DCACHE_PERF_EN
        chk("rstf_perf_hits", {16'b0, hit_count}, 32'd0);
        chk("rstf_perf_misses", {16'b0, miss_count}, 32'd0);
`endif
        run_miss(busy, saw_wb, saw_upd, wb_addr, wb_data, f_addr);
        chk("rstf_refill_busy", busy, 32'd6);
        chk("rstf_refill_no_wb", {31'b0, saw_wb}, 32'd0);
        chk("rstf_refill_addr", {26'b0, f_addr}, 32'h00);
        chk("rstf_refill_readdata", {24'b0, bus.readdata}, 32'hAA);

        @(posedge clock);
        #1 bus.read = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
